// File: rtl/keypad_scan_debounce.sv
// Purpose: 4x4 keypad row scanner with single-key press/release debounce; emits key_valid + key_code.
// Latency: a press is reported one cycle after the DEBOUNCE_CNT-th consecutive matching dwell sample.
// Backpressure: none; key_valid is a one-cycle pulse that the hit checker must take when it appears.
// Optional auto-repeat while a key is held is compiled in with `define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_debounce #(
  parameter int SCAN_DIV      = 250000,
  parameter int DEBOUNCE_CNT  = 3,
  parameter int REPEAT_DWELLS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MATCH_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(DEBOUNCE_CNT);

  // A dwell shorter than 2 cycles or a debounce depth below 2 breaks the sample/match accounting.
  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_DWELLS < 1) begin : g_param_check
    $error("keypad_scan_debounce: SCAN_DIV>=2, DEBOUNCE_CNT>=2, REPEAT_DWELLS>=1 required");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           row_q, row_d;
  logic [1:0]           col_q, col_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic                 key_valid_q, key_valid_d;
  logic [3:0]           key_code_q, key_code_d;
  logic                 key_held_q, key_held_d;

  logic                 sample;
  logic                 col_one;
  logic [1:0]           col_idx;
  logic                 col_match;
  logic                 col_open;
  logic [MATCH_W-1:0]   match_inc;
  logic                 match_full;
  logic                 rep_pulse;

  assign sample     = (cnt_q == CNT_LAST);
  assign col_open   = (keypadCol == 4'b1111);
  assign col_match  = col_one && (col_idx == col_q);
  assign match_inc  = match_q + MATCH_W'(1);
  assign match_full = (match_inc == MATCH_DONE);

  // Decode a single active-low column; ghosting (two or more lows) counts as no key.
  always_comb begin
    col_one = 1'b1;
    col_idx = 2'd0;
    case (keypadCol)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_one = 1'b0;
    endcase
  end

  // State register plus all datapath flops; reset aborts everything in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      match_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      match_q     <= match_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next state: transitions only happen on the sample cycle; disable parks the FSM in SCAN.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = SCAN;
    end else if (sample) begin
      case (state_q)
        SCAN:     if (col_one) state_d = DEBOUNCE;
        DEBOUNCE: begin
          if (!col_match)      state_d = SCAN;
          else if (match_full) state_d = PRESSED;
        end
        PRESSED:  if (col_open) state_d = RELEASE;
        RELEASE:  begin
          if (!col_open)       state_d = PRESSED;
          else if (match_full) state_d = SCAN;
        end
        default:  state_d = SCAN;
      endcase
    end
  end

  // Datapath/outputs: dwell counter, row strobe, match counter and the registered key outputs.
  always_comb begin
    cnt_d       = sample ? '0 : cnt_q + CNT_W'(1);
    row_d       = row_q;
    col_d       = col_q;
    match_d     = match_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    if (!enable) begin
      // Scanning keeps running so the row strobe is live when the game restarts.
      match_d    = '0;
      key_held_d = 1'b0;
      if (sample) row_d = row_q + 2'd1;
    end else if (sample) begin
      case (state_q)
        SCAN: begin
          if (col_one) begin
            col_d   = col_idx;
            match_d = MATCH_W'(1);
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!col_match) begin
            match_d = '0;
            row_d   = row_q + 2'd1;
          end else if (match_full) begin
            match_d     = '0;
            key_valid_d = 1'b1;
            key_code_d  = ~{row_q, col_q};
            key_held_d  = 1'b1;
          end else begin
            match_d = match_inc;
          end
        end
        PRESSED: begin
          if (col_open) match_d = MATCH_W'(1);
        end
        RELEASE: begin
          if (!col_open) begin
            match_d = '0;
          end else if (match_full) begin
            match_d    = '0;
            key_held_d = 1'b0;
            row_d      = row_q + 2'd1;
          end else begin
            match_d = match_inc;
          end
        end
        default: match_d = '0;
      endcase
    end
    key_valid_d = key_valid_d | rep_pulse;
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DWELLS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DWELLS - 1);
  logic [REP_W-1:0] rep_q, rep_d;

  // Repeat counter lives only in PRESSED, so every entry into PRESSED starts from zero.
  always_comb begin
    rep_d     = rep_q;
    rep_pulse = 1'b0;
    if (!enable || state_q != PRESSED) begin
      rep_d = '0;
    end else if (sample && !col_open) begin
      if (rep_q == REP_LAST) begin
        rep_d     = '0;
        rep_pulse = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign keypadRow = 4'b1111 ^ (4'b0001 << row_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DWELLS=2.
// A tiny physical keypad model drives keypadCol from the live row strobe.
// Cycle index cyc counts clock edges since reset release; samples fall on cyc = 4k+3.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE_CNT  = 3;
  localparam int REPEAT_DWELLS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] keypadCol = 4'b1111;
  logic [3:0] keypadRow;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses;
  int first_pulse;
  int last_pulse;
  int gap_ok;
  int row_ok;
  logic [3:0] exp_row;
  logic contact;

  keypad_scan_debounce #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DWELLS(REPEAT_DWELLS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .keypadCol(keypadCol),
    .keypadRow(keypadRow),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    enable    = 1'b1;
    keypadCol = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  // Columns seen when key (krow,kcol) is physically closed and row strobe is row.
  function automatic logic [3:0] key_col(input logic [3:0] row, input logic [3:0] krow,
                                         input logic [3:0] kcol, input logic down);
    return (down && row == krow) ? kcol : 4'b1111;
  endfunction

  task automatic note_pulse();
    if (key_valid) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  initial begin
    // 1. reset values and idle scanning
    do_reset();
    check("rst_row", keypadRow, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      note_pulse();
      exp_row = 4'b1111 ^ (4'b0001 << ((cyc / 4) % 4));
      check("idle_row", keypadRow, exp_row);
    end
    check("idle_pulses", pulses, 0);
    check("idle_code", key_code, 0);

    // 2. key 14 (row 1110 / col 1101) held from the start
    do_reset();
    pulses = 0; first_pulse = -1; row_ok = 1;
    for (int i = 0; i < 18; i++) begin
      keypadCol = key_col(keypadRow, 4'b1110, 4'b1101, 1'b1);
      tick();
      note_pulse();
      if (keypadRow != 4'b1110) row_ok = 0;
    end
    check("k14_pulses", pulses, 1);
    check("k14_latency", first_pulse, 12);
    check("k14_code", key_code, 14);
    check("k14_held", key_held, 1);
    check("k14_row_frozen", row_ok, 1);

    // 3+4. bouncing press of key 9 (row 1101 / col 1011), then glitchy release
    do_reset();
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 64; i++) begin
      contact = (cyc < 8) || (cyc >= 24 && cyc < 40) || (cyc >= 44 && cyc < 48);
      keypadCol = key_col(keypadRow, 4'b1101, 4'b1011, contact);
      tick();
      note_pulse();
      if (cyc == 12) check("bounce_abort_row", keypadRow, 4'b1011);
      if (cyc == 50) check("glitch_held", key_held, 1);
      if (cyc == 58) check("release_held_mid", key_held, 1);
      if (cyc == 59) check("release_row_frozen", keypadRow, 4'b1101);
      if (cyc == 60) begin
        check("release_held", key_held, 0);
        check("release_row_adv", keypadRow, 4'b1011);
      end
    end
    check("k9_pulses", pulses, 1);
    check("k9_latency", first_pulse, 36);
    check("k9_code", key_code, 9);
    enable = 1'b0;
    keypadCol = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      note_pulse();
    end
    check("dis_code_kept", key_code, 9);
    check("dis_pulses", pulses, 1);
    enable = 1'b1;

    // 5a. key 0 (row 0111 / col 0111) held, then enable drops
    do_reset();
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 26; i++) begin
      keypadCol = key_col(keypadRow, 4'b0111, 4'b0111, 1'b1);
      tick();
      note_pulse();
    end
    check("k0_pulses", pulses, 1);
    check("k0_latency", first_pulse, 24);
    check("k0_held", key_held, 1);
    enable = 1'b0;
    keypadCol = key_col(keypadRow, 4'b0111, 4'b0111, 1'b1);
    tick();
    check("dis_held", key_held, 0);
    check("dis_valid", key_valid, 0);
    keypadCol = key_col(keypadRow, 4'b0111, 4'b0111, 1'b1);
    tick();
    check("dis_scan_row", keypadRow, 4'b1110);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      keypadCol = key_col(keypadRow, 4'b0111, 4'b0111, 1'b1);
      tick();
      note_pulse();
    end
    check("dis_no_pulse", pulses, 0);
    check("dis_k0_code", key_code, 0);
    enable = 1'b1;

    // 5b. reset in the middle of debouncing a key on row 1011
    do_reset();
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 17; i++) begin
      keypadCol = key_col(keypadRow, 4'b1011, 4'b1110, 1'b1);
      tick();
      note_pulse();
    end
    check("deb_row_frozen", keypadRow, 4'b1011);
    rst = 1'b0;
    keypadCol = 4'b1111;
    tick();
    check("midrst_row", keypadRow, 4'b1110);
    check("midrst_valid", key_valid, 0);
    check("midrst_held", key_held, 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      note_pulse();
    end
    check("midrst_pulses", pulses, 0);

    // 6. key 15 held for 40 cycles: auto-repeat every 8 cycles when compiled in
    do_reset();
    pulses = 0; first_pulse = -1; last_pulse = -1; gap_ok = 1;
    for (int i = 0; i < 40; i++) begin
      keypadCol = key_col(keypadRow, 4'b1110, 4'b1110, 1'b1);
      tick();
      note_pulse();
      if (key_valid) begin
        check("rep_code", key_code, 15);
        if (last_pulse >= 0 && cyc - last_pulse != 8) gap_ok = 0;
        last_pulse = cyc;
      end
    end
    check("rep_first", first_pulse, 12);
    check("rep_gap", gap_ok, 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("rep_pulses", pulses, 4);
`else
    check("rep_pulses", pulses, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
